// File: rtl/bus_memory_responder_pkg.sv
// Shared types and constants for the bus memory responder.
package internal_defines;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;

endpackage

// File: rtl/bus_memory_responder_storage.sv
// Byte-wide storage array: synchronous write, asynchronous read, cleared on reset.
module responder_storage #(
  parameter int DEPTH = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic          in_range;
  logic [AW-1:0] idx;

  // Addresses past the end of a short array are never touched and read as zero.
  assign in_range = ({1'b0, addr_i} < 9'(DEPTH));
  assign idx      = addr_i[AW-1:0];
  assign rdata_o  = in_range ? mem_q[idx] : 8'h00;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (we_i && in_range) begin
      mem_q[idx] <= wdata_i;
    end
  end

endmodule

// File: rtl/bus_memory_responder.sv
// Responder for CPU data-memory byte requests with configurable wait states
// and a memory-mapped output latch.
module bus_memory_responder
  import internal_defines::*;
#(
  parameter int         DEPTH       = 256,
  parameter int         WAIT_CYCLES = 2,
  parameter logic [7:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_rdata,
  output logic [7:0] io_out,
  output logic       io_strobe,
  output logic       busy
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  resp_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_write_q, hold_write_d;
  logic [7:0]    hold_addr_q, hold_addr_d;
  logic [7:0]    hold_wdata_q, hold_wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    io_q, io_d;
  logic          strobe_q, strobe_d;

  logic          acc_write;
  logic [7:0]    acc_addr;
  logic [7:0]    acc_wdata;
  logic          acc_is_io;
  logic          do_access;
  logic          store_we;
  logic [7:0]    store_rdata;

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request rather than the holding registers.
  assign acc_write = (state_q == IDLE) ? req_write : hold_write_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : hold_addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : hold_wdata_q;
  assign acc_is_io = (acc_addr == IO_ADDR);

  responder_storage #(.DEPTH(DEPTH)) u_storage (
    .clock   (clock),
    .reset   (reset),
    .we_i    (store_we),
    .addr_i  (acc_addr),
    .wdata_i (acc_wdata),
    .rdata_o (store_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_write_d = hold_write_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    rdata_d      = rdata_q;
    io_d         = io_q;
    strobe_d     = 1'b0;
    do_access    = 1'b0;
    store_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          hold_write_d = req_write;
          hold_addr_d  = req_addr;
          hold_wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = CW'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_access) begin
      if (acc_write) begin
        rdata_d = acc_wdata;
        if (acc_is_io) begin
          io_d     = acc_wdata;
          strobe_d = 1'b1;
        end else begin
          store_we = 1'b1;
        end
      end else begin
        rdata_d = acc_is_io ? io_q : store_rdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_write_q <= 1'b0;
      hold_addr_q  <= 8'h00;
      hold_wdata_q <= 8'h00;
      rdata_q      <= 8'h00;
      io_q         <= 8'h00;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_write_q <= hold_write_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      rdata_q      <= rdata_d;
      io_q         <= io_d;
      strobe_q     <= strobe_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;
  assign io_out     = io_q;
  assign io_strobe  = strobe_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Bench: instance 0 has two wait states and full depth, instance 1 has zero
// wait states and a 64-byte array.
module tb_bus_memory_responder;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      req_valid, req_write, resp_ready;
  logic [1:0][7:0] req_addr, req_wdata;
  wire  [1:0]      req_ready, resp_valid, io_strobe, busy;
  wire  [1:0][7:0] resp_rdata, io_out;

  int total = 0;
  int bad   = 0;
  int strobe_cnt [2] = '{0, 0};
  logic [7:0] sbq0 [$];
  logic [7:0] sbq1 [$];

  typedef struct {
    bit         sel;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [$];

  always #5 clock = ~clock;

  bus_memory_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .io_out(io_out[0]), .io_strobe(io_strobe[0]), .busy(busy[0])
  );

  bus_memory_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .io_out(io_out[1]), .io_strobe(io_strobe[1]), .busy(busy[1])
  );

  always @(posedge clock) begin
    if (io_strobe[0]) strobe_cnt[0]++;
    if (io_strobe[1]) strobe_cnt[1]++;
  end

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic txn(input int s, input bit wr, input logic [7:0] addr,
                     input logic [7:0] wdata, input logic [7:0] exp, input string nm);
    int n;
    int lat;
    int sc0;
    logic [7:0] e;
    @(negedge clock);
    req_valid[s] = 1'b1; req_write[s] = wr; req_addr[s] = addr; req_wdata[s] = wdata;
    n = 0;
    while (!req_ready[s] && n < 20) begin @(negedge clock); n++; end
    if (!req_ready[s]) begin
      check({nm, "_accept_timeout"}, 0, 1);
      req_valid[s] = 1'b0;
      return;
    end
    sc0 = strobe_cnt[s];
    @(posedge clock);
    if (s == 0) sbq0.push_back(exp); else sbq1.push_back(exp);
    @(negedge clock);
    req_valid[s] = 1'b0;
    req_wdata[s] = ~wdata;
    lat = 1;
    while (!resp_valid[s] && lat < 20) begin @(negedge clock); lat++; end
    check({nm, "_latency"}, lat, (s == 0) ? 3 : 1);
    if (!resp_valid[s]) return;
    e = (s == 0) ? sbq0.pop_front() : sbq1.pop_front();
    check({nm, "_rdata"}, resp_rdata[s], e);
    resp_ready[s] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready[s] = 1'b0;
    check({nm, "_strobes"}, strobe_cnt[s] - sc0, (wr && addr == 8'hFF) ? 1 : 0);
  endtask

  initial begin
    int n;
    bit ok;
    reset = 1'b1;
    req_valid = '0; req_write = '0; resp_ready = '0;
    req_addr = '0; req_wdata = '0;

    // sel, write, addr, wdata, expected rdata
    vecs.push_back('{1'b0, 1'b0, 8'h10, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 8'h10, 8'hA5, 8'hA5});
    vecs.push_back('{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5});
    vecs.push_back('{1'b0, 1'b1, 8'h11, 8'h5A, 8'h5A});
    vecs.push_back('{1'b0, 1'b0, 8'h11, 8'h00, 8'h5A});
    vecs.push_back('{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5});
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h3C, 8'h3C});
    vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C});
    vecs.push_back('{1'b0, 1'b1, 8'hFE, 8'h81, 8'h81});
    vecs.push_back('{1'b0, 1'b0, 8'hFE, 8'h00, 8'h81});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 8'h20, 8'h01, 8'h01});
    vecs.push_back('{1'b1, 1'b1, 8'h20, 8'h02, 8'h02});
    vecs.push_back('{1'b1, 1'b0, 8'h20, 8'h00, 8'h02});
    vecs.push_back('{1'b1, 1'b1, 8'h3F, 8'h44, 8'h44});
    vecs.push_back('{1'b1, 1'b0, 8'h3F, 8'h00, 8'h44});
    vecs.push_back('{1'b1, 1'b1, 8'h50, 8'h99, 8'h99});
    vecs.push_back('{1'b1, 1'b0, 8'h50, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h40, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 8'hFF, 8'h12, 8'h12});
    vecs.push_back('{1'b1, 1'b0, 8'hFF, 8'h00, 8'h12});

    @(posedge clock); @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_req_ready", req_ready[0], 1);
    check("rst_resp_valid", resp_valid[0], 0);
    check("rst_io_out", io_out[0], 8'h00);
    check("rst_busy", busy[0], 0);
    check("rst_rdata", resp_rdata[0], 8'h00);

    foreach (vecs[i])
      txn(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
          $sformatf("vec%0d", i));

    check("io_out_a", io_out[0], 8'h3C);
    check("io_out_b", io_out[1], 8'h12);
    check("io_store_untouched", dut_a.u_storage.mem_q[255], 8'h00);

    // Backpressure: response held for 5 cycles while request inputs toggle.
    @(negedge clock);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h10;
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h10; req_wdata[0] = 8'hEE;
    n = 0;
    while (!resp_valid[0] && n < 20) begin @(negedge clock); n++; end
    check("bp_latency", n + 1, 3);
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (!resp_valid[0] || resp_rdata[0] != 8'hA5 || req_ready[0] || !busy[0]) ok = 1'b0;
      req_addr[0] = 8'(c);
      @(negedge clock);
    end
    check("bp_stable", ok, 1);
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    check("bp_ready_low_before", req_ready[0], 0);
    @(posedge clock);
    @(negedge clock);
    resp_ready[0] = 1'b0;
    check("bp_ready_after", req_ready[0], 1);
    check("bp_valid_after", resp_valid[0], 0);
    txn(0, 1'b0, 8'h10, 8'h00, 8'hA5, "bp_no_write");

    // Reset during the wait phase of a write abandons it.
    @(negedge clock);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h30; req_wdata[0] = 8'h77;
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    check("mid_busy", busy[0], 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid[0] || !req_ready[0]) ok = 1'b0;
      @(negedge clock);
    end
    check("mid_no_resp", ok, 1);
    check("mid_io_a", io_out[0], 8'h00);
    check("mid_io_b", io_out[1], 8'h00);
    txn(0, 1'b0, 8'h30, 8'h00, 8'h00, "mid_read30");
    txn(0, 1'b0, 8'h10, 8'h00, 8'h00, "mid_cleared10");
    txn(1, 1'b0, 8'h20, 8'h00, 8'h00, "mid_cleared20");

    check("sb_empty", sbq0.size() + sbq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=expired want=done");
    $fatal(1, "timeout");
  end

endmodule
